mem_req_ctrl: RTL and testbench

Initiator-side controller for the single-port byte-enabled register-file RAM. It accepts byte-addressed load/store requests over a valid/ready channel and converts each one into one or two RAM word accesses, using address, write, byte enable and data. Loads are assembled from RAM dout and sign- or zero-extended. Responses return over a valid/ready channel. It sits between a core load/store stage and the RAM macro.

---
 rtl/mem_ctrl_pkg.sv | 35 +++
 rtl/mem_lane_align.sv | 33 +++
 rtl/mem_req_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-addressed RAM request controller.
// Holds the FSM state encoding, access-size codes and the byte-lane mask predicate.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] nb;
    nb = 4'd1;
    case (size)
      SZ_B: nb = 4'd1;
      SZ_H: nb = 4'd2;
      SZ_W: nb = 4'd4;
      SZ_D: nb = 4'd8;
      default: nb = 4'd1;
    endcase
    return nb;
  endfunction

  // part=0: lanes off..min(off+nbytes,nb)-1 of the first word;
  // part=1: lanes 0..off+nbytes-nb-1 of the following word.
  function automatic logic byte_in_mask(input int off, input int nbytes,
                                        input logic part, input int nb, input int idx);
    logic hit;
    if (!part) hit = (idx >= off) && (idx < off + nbytes) && (idx < nb);
    else       hit = (idx < off + nbytes - nb);
    return hit;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane rotator (left for stores, right for loads) with the
// matching per-lane byte mask for the first or second word of an access.
module mem_lane_align
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit LEFT  = 1'b1
) (
  input  logic [WIDTH-1:0]             i_data,
  input  logic [$clog2(WIDTH/8)-1:0]   i_off,
  input  logic [3:0]                   i_nbytes,
  input  logic                         i_part,
  output logic [WIDTH-1:0]             o_data,
  output logic [WIDTH/8-1:0]           o_mask
);

  localparam int NB = WIDTH / 8;

  // Data and mask are kept in separate processes so the load path can feed
  // the mask back into the data input without a combinational block cycle.
  always_comb begin
    o_data = '0;
    for (int j = 0; j < NB; j++) begin
      if (LEFT) o_data[j*8 +: 8] = i_data[((j + NB - int'(i_off)) % NB)*8 +: 8];
      else      o_data[j*8 +: 8] = i_data[((j + int'(i_off)) % NB)*8 +: 8];
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_mask
    assign o_mask[gi] = byte_in_mask(int'(i_off), int'(i_nbytes), i_part, NB, gi);
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Load/store request controller for a single-port byte-enabled RAM: splits
// unaligned accesses into two word cycles and returns extended load data.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                                          eph1,
  input  logic                                          resetn,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic                                          req_write,
  input  logic [$clog2(DEPTH)+$clog2(WIDTH/8)-1:0]      req_addr,
  input  logic [1:0]                                    req_size,
  input  logic                                          req_signed,
  input  logic [WIDTH-1:0]                              req_wdata,
  output logic                                          rsp_valid,
  input  logic                                          rsp_ready,
  output logic [WIDTH-1:0]                              rsp_rdata,
  output logic                                          rsp_err,
  output logic                                          mem_write,
  output logic [$clog2(DEPTH)-1:0]                      mem_addr,
  output logic [WIDTH/8-1:0]                            mem_wben,
  output logic [WIDTH-1:0]                              mem_din,
  input  logic [WIDTH-1:0]                              mem_dout
);

  localparam int NB = WIDTH / 8;
  localparam int BW = $clog2(NB);
  localparam int MW = $clog2(DEPTH);
  localparam int AW = MW + BW;

  state_t           r_state, w_state_next;
  logic             r_write, r_signed, r_split, r_err;
  logic [BW-1:0]    r_off;
  logic [MW-1:0]    r_widx, r_mem_addr;
  logic [1:0]       r_size;
  logic [WIDTH-1:0] r_wdata, r_lo, r_rdata;

  logic [BW-1:0]    w_req_off;
  logic [MW-1:0]    w_req_widx;
  logic [3:0]       w_req_nb, w_nbytes;
  logic             w_req_split, w_req_err;
  logic [WIDTH-1:0] w_st_data, w_ld_merge, w_ld_rot, w_ld_bits, w_ext;
  logic [NB-1:0]    w_st_mask, w_ld_mask;
  logic             w_sign;

  assign w_req_off   = req_addr[BW-1:0];
  assign w_req_widx  = req_addr[AW-1:BW];
  assign w_req_nb    = size_bytes(req_size);
  assign w_req_split = (int'(w_req_off) + int'(w_req_nb)) > NB;
  // The last word has no successor; a split there is rejected, never wrapped.
  assign w_req_err   = (int'(w_req_nb) > NB) ||
                       (w_req_split && (int'(w_req_widx) == DEPTH - 1));
  assign w_nbytes    = size_bytes(r_size);

  mem_lane_align #(.WIDTH(WIDTH), .LEFT(1'b1)) u_store_align (
    .i_data   (r_wdata),
    .i_off    (r_off),
    .i_nbytes (w_nbytes),
    .i_part   (r_state == ACC1),
    .o_data   (w_st_data),
    .o_mask   (w_st_mask)
  );

  for (genvar gi = 0; gi < NB; gi++) begin : g_ld_bits
    assign w_ld_bits[gi*8 +: 8] = {8{w_ld_mask[gi]}};
  end

  // Low-part lanes come from the first word, everything else from the second;
  // lanes above the access size are overwritten by the extension below.
  assign w_ld_merge = r_split ? ((r_lo & w_ld_bits) | (mem_dout & ~w_ld_bits)) : mem_dout;

  mem_lane_align #(.WIDTH(WIDTH), .LEFT(1'b0)) u_load_align (
    .i_data   (w_ld_merge),
    .i_off    (r_off),
    .i_nbytes (w_nbytes),
    .i_part   (1'b0),
    .o_data   (w_ld_rot),
    .o_mask   (w_ld_mask)
  );

  always_comb begin
    w_sign = 1'b0;
    for (int j = 0; j < NB; j++) begin
      if (j == int'(w_nbytes) - 1) w_sign = r_signed & w_ld_rot[j*8+7];
    end
    w_ext = w_ld_rot;
    for (int j = 0; j < NB; j++) begin
      if (j >= int'(w_nbytes)) w_ext[j*8 +: 8] = {8{w_sign}};
    end
  end

  always_ff @(posedge eph1 or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    mem_write    = 1'b0;
    mem_wben     = '0;
    mem_din      = '0;
    mem_addr     = r_mem_addr;
    case (r_state)
      IDLE: begin
        req_ready = resetn;
        if (req_valid) w_state_next = w_req_err ? RESP : ACC0;
      end
      ACC0: begin
        mem_addr = r_widx;
        if (r_write) begin
          mem_write = 1'b1;
          mem_wben  = w_st_mask;
          mem_din   = w_st_data;
        end
        if (r_split)      w_state_next = ACC1;
        else if (r_write) w_state_next = RESP;
        else              w_state_next = CAP;
      end
      ACC1: begin
        mem_addr = r_widx + MW'(1);
        if (r_write) begin
          mem_write = 1'b1;
          mem_wben  = w_st_mask;
          mem_din   = w_st_data;
        end
        w_state_next = r_write ? RESP : CAP;
      end
      CAP:  w_state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge eph1 or negedge resetn) begin
    if (!resetn) begin
      r_write    <= 1'b0;
      r_signed   <= 1'b0;
      r_split    <= 1'b0;
      r_err      <= 1'b0;
      r_off      <= '0;
      r_widx     <= '0;
      r_size     <= '0;
      r_wdata    <= '0;
      r_lo       <= '0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_signed <= req_signed;
            r_off    <= w_req_off;
            r_widx   <= w_req_widx;
            r_size   <= req_size;
            r_wdata  <= req_wdata;
            r_split  <= w_req_split;
            r_err    <= w_req_err;
            r_lo     <= '0;
            r_rdata  <= '0;
          end
        end
        ACC1:    r_lo    <= mem_dout;
        CAP:     r_rdata <= w_ext;
        default: ;
      endcase
      if (r_state == ACC0 || r_state == ACC1) r_mem_addr <= mem_addr;
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural byte-enabled RAM attached;
// expected data, latencies and bus activity are hand-computed constants.
module tb_mem_req_ctrl;

  logic        eph1 = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [4:0]  req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_write;
  logic [2:0]  mem_addr;
  logic [3:0]  mem_wben;
  logic [31:0] mem_din, mem_dout;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] ram [0:7];
  logic        ram_clr;

  logic        tr_write [0:15];
  logic [2:0]  tr_addr  [0:15];
  logic [3:0]  tr_wben  [0:15];
  logic [31:0] tr_din   [0:15];

  always #5 eph1 = ~eph1;

  mem_req_ctrl #(.DEPTH(8), .WIDTH(32)) dut (
    .eph1       (eph1),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wben   (mem_wben),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  always @(posedge eph1) begin
    if (ram_clr) begin
      for (int i = 0; i < 8; i++) ram[i] <= '0;
    end else if (mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_wben[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
    end
    mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [4:0] addr,
                        input logic [1:0] size, input logic sgn, input logic [31:0] wd,
                        input int hold, input int exp_lat, input logic [31:0] exp_rd,
                        input logic exp_err);
    int lat;
    int nwr;
    int exp_nwr;
    for (int i = 0; i < 16; i++) begin
      tr_write[i] = 1'b0; tr_addr[i] = '0; tr_wben[i] = '0; tr_din[i] = '0;
    end
    @(negedge eph1);
    chk({tag, ":ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_size = size; req_signed = sgn; req_wdata = wd;
    @(posedge eph1);
    @(negedge eph1);
    req_valid = 1'b0;
    lat = 1;
    nwr = 0;
    while (!rsp_valid && lat < 12) begin
      tr_write[lat] = mem_write; tr_addr[lat] = mem_addr;
      tr_wben[lat] = mem_wben;   tr_din[lat] = mem_din;
      if (mem_write) nwr++;
      chk({tag, ":busy"}, 32'(req_ready), 32'd0);
      @(negedge eph1);
      lat++;
    end
    if (mem_write) nwr++;
    exp_nwr = (!wr || exp_err) ? 0 : exp_lat - 1;
    chk({tag, ":lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":rdata"}, rsp_rdata, exp_rd);
    chk({tag, ":err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, ":nwrites"}, 32'(nwr), 32'(exp_nwr));
    for (int h = 0; h < hold; h++) begin
      @(negedge eph1);
      chk({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ":hold_rdata"}, rsp_rdata, exp_rd);
      chk({tag, ":hold_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge eph1);
    @(negedge eph1);
    rsp_ready = 1'b0;
    chk({tag, ":rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, ":idle_ready"}, 32'(req_ready), 32'd1);
    $display("txn %-12s %s addr=%h size=%0d signed=%b wdata=%h -> rdata=%h err=%b lat=%0d",
             tag, wr ? "ST" : "LD", addr, size, sgn, wd, rsp_rdata, rsp_err, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; ram_clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_signed = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    #3;
    chk("rst:req_ready", 32'(req_ready), 32'd0);
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:rsp_err", 32'(rsp_err), 32'd0);
    chk("rst:rsp_rdata", rsp_rdata, 32'd0);
    chk("rst:mem_write", 32'(mem_write), 32'd0);
    chk("rst:mem_addr", 32'(mem_addr), 32'd0);
    chk("rst:mem_wben", 32'(mem_wben), 32'd0);
    chk("rst:mem_din", mem_din, 32'd0);
    repeat (3) @(negedge eph1);
    resetn = 1'b1; ram_clr = 1'b0;

    do_req("st_w4", 1'b1, 5'h04, 2'd2, 1'b0, 32'hDEADBEEF, 0, 2, 32'h0, 1'b0);
    chk("st_w4:acc0_addr", 32'(tr_addr[1]), 32'd1);
    chk("st_w4:acc0_wben", 32'(tr_wben[1]), 32'hF);
    chk("st_w4:acc0_din", tr_din[1], 32'hDEADBEEF);
    do_req("ld_w4", 1'b0, 5'h04, 2'd2, 1'b0, 32'h0, 0, 3, 32'hDEADBEEF, 1'b0);

    do_req("st_b7", 1'b1, 5'h07, 2'd0, 1'b0, 32'h00000080, 0, 2, 32'h0, 1'b0);
    chk("st_b7:acc0_addr", 32'(tr_addr[1]), 32'd1);
    chk("st_b7:acc0_wben", 32'(tr_wben[1]), 32'h8);
    chk("st_b7:acc0_din_b3", 32'(tr_din[1][31:24]), 32'h80);
    do_req("ld_sb7", 1'b0, 5'h07, 2'd0, 1'b1, 32'h0, 0, 3, 32'hFFFFFF80, 1'b0);
    do_req("ld_ub7", 1'b0, 5'h07, 2'd0, 1'b0, 32'h0, 0, 3, 32'h00000080, 1'b0);
    do_req("ld_sh4", 1'b0, 5'h04, 2'd1, 1'b1, 32'h0, 0, 3, 32'hFFFFBEEF, 1'b0);
    do_req("ld_uh6", 1'b0, 5'h06, 2'd1, 1'b0, 32'h0, 0, 3, 32'h000080AD, 1'b0);

    do_req("st_w6", 1'b1, 5'h06, 2'd2, 1'b0, 32'h11223344, 0, 3, 32'h0, 1'b0);
    chk("st_w6:acc0_addr", 32'(tr_addr[1]), 32'd1);
    chk("st_w6:acc0_wben", 32'(tr_wben[1]), 32'hC);
    chk("st_w6:acc0_din_hi", 32'(tr_din[1][31:16]), 32'h3344);
    chk("st_w6:acc1_addr", 32'(tr_addr[2]), 32'd2);
    chk("st_w6:acc1_wben", 32'(tr_wben[2]), 32'h3);
    chk("st_w6:acc1_din_lo", 32'(tr_din[2][15:0]), 32'h1122);
    chk("st_w6:ram1", ram[1], 32'h3344BEEF);
    chk("st_w6:ram2", ram[2], 32'h00001122);
    do_req("ld_w6", 1'b0, 5'h06, 2'd2, 1'b0, 32'h0, 0, 4, 32'h11223344, 1'b0);
    do_req("ld_sh7", 1'b0, 5'h07, 2'd1, 1'b1, 32'h0, 0, 4, 32'h00002233, 1'b0);

    do_req("ld_w1e_err", 1'b0, 5'h1E, 2'd2, 1'b0, 32'h0, 0, 1, 32'h0, 1'b1);
    do_req("ld_d_err", 1'b0, 5'h00, 2'd3, 1'b0, 32'h0, 0, 1, 32'h0, 1'b1);
    do_req("st_d_err", 1'b1, 5'h08, 2'd3, 1'b0, 32'h55555555, 0, 1, 32'h0, 1'b1);
    chk("st_d_err:ram2", ram[2], 32'h00001122);
    do_req("st_b1f", 1'b1, 5'h1F, 2'd0, 1'b0, 32'h000000A5, 0, 2, 32'h0, 1'b0);
    do_req("ld_sb1f", 1'b0, 5'h1F, 2'd0, 1'b1, 32'h0, 0, 3, 32'hFFFFFFA5, 1'b0);

    do_req("ld_w4_hold", 1'b0, 5'h04, 2'd2, 1'b0, 32'h0, 5, 3, 32'h3344BEEF, 1'b0);

    // Reset in the middle of a split store: first word written, second untouched.
    @(negedge eph1);
    chk("rst_acc1:ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h06;
    req_size = 2'd2; req_signed = 1'b0; req_wdata = 32'hAABBCCDD;
    @(posedge eph1);
    @(negedge eph1);
    req_valid = 1'b0;
    chk("rst_acc1:acc0_write", 32'(mem_write), 32'd1);
    @(negedge eph1);
    chk("rst_acc1:acc1_addr", 32'(mem_addr), 32'd2);
    chk("rst_acc1:acc1_wben", 32'(mem_wben), 32'h3);
    resetn = 1'b0;
    #1;
    chk("rst_acc1:req_ready", 32'(req_ready), 32'd0);
    chk("rst_acc1:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_acc1:mem_write", 32'(mem_write), 32'd0);
    chk("rst_acc1:mem_wben", 32'(mem_wben), 32'd0);
    chk("rst_acc1:mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_acc1:mem_din", mem_din, 32'd0);
    @(negedge eph1);
    chk("rst_acc1:ram1", ram[1], 32'hCCDDBEEF);
    chk("rst_acc1:ram2", ram[2], 32'h00001122);
    resetn = 1'b1;
    @(negedge eph1);
    chk("rst_acc1:ready_after", 32'(req_ready), 32'd1);
    $display("txn %-12s ST addr=06 size=2 wdata=aabbccdd interrupted by reset in ACC1", "st_w6_rst");
    do_req("ld_w4_post", 1'b0, 5'h04, 2'd2, 1'b0, 32'h0, 0, 3, 32'hCCDDBEEF, 1'b0);
    do_req("ld_w8_post", 1'b0, 5'h08, 2'd2, 1'b0, 32'h0, 0, 3, 32'h00001122, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
